// File: rtl/mem_request_arbiter_pkg.sv
// Shared encodings for the memory request arbiter: access lengths,
// arbiter states and client identifiers.
package mem_request_arbiter_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY_IF = 2'b01,
        ST_BUSY_LS = 2'b10,
        ST_GAP     = 2'b11
    } arb_state_e;

    typedef enum logic {
        CLI_IF = 1'b0,
        CLI_LS = 1'b1
    } client_e;

endpackage

// File: rtl/mem_request_arbiter_pick.sv
// Winner select between IF and LS requests; with MEM_ARB_ROUND_ROBIN_EN
// defined it alternates on conflict, otherwise LS has fixed priority.
module mem_arb_pick
    import mem_request_arbiter_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic rdy_in,
    input  logic grant_en,
`endif
    input  logic if_req,
    input  logic ls_req,
    output logic pick_ls,
    output logic pick_any
);

    assign pick_any = if_req || ls_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    client_e last_grant;

    // On conflict, favour whichever client was not served last
    assign pick_ls = ls_req && (!if_req || (last_grant == CLI_IF));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant <= CLI_IF;
        end else if (rdy_in && grant_en && pick_any) begin
            last_grant <= pick_ls ? CLI_LS : CLI_IF;
        end
    end
`else
    assign pick_ls = ls_req;
`endif

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates IF and LS clients onto the byte-serial memory controller port.
// Arbitration policy selected by MEM_ARB_ROUND_ROBIN_EN (default: LS priority).
module mem_request_arbiter
    import mem_request_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [XLEN-1:0]   if_data,
    input  logic              ls_valid,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_len,
    input  logic [XLEN-1:0]   ls_data,
    output logic              ls_ready,
    output logic [XLEN-1:0]   ls_res,
    output logic              mc_valid,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [1:0]        mc_len,
    output logic [XLEN-1:0]   mc_data,
    input  logic              mc_ready,
    input  logic [XLEN-1:0]   mc_res
);

    arb_state_e        state_q, state_d;
    logic              drop_q, drop_d;
    logic              mc_valid_d, mc_wr_d;
    logic [ADDR_W-1:0] mc_addr_d;
    logic [1:0]        mc_len_d;
    logic [XLEN-1:0]   mc_data_d;
    logic              if_ready_d, ls_ready_d;
    logic [XLEN-1:0]   if_data_d, ls_res_d;
    logic [XLEN-1:0]   ls_ext;
    logic              if_req, pick_ls, pick_any;

    assign if_req = if_valid && !flush_in;

    mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .grant_en (state_q == ST_IDLE),
`endif
        .if_req   (if_req),
        .ls_req   (ls_valid),
        .pick_ls  (pick_ls),
        .pick_any (pick_any)
    );

    always_comb begin
        ls_ext = mc_res;
        unique case (mc_len)
            LEN_BYTE: ls_ext = {{(XLEN-8){1'b0}}, mc_res[7:0]};
            LEN_HALF: ls_ext = {{(XLEN-16){1'b0}}, mc_res[15:0]};
            default:  ls_ext = mc_res;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        mc_valid_d = mc_valid;
        mc_wr_d    = mc_wr;
        mc_addr_d  = mc_addr;
        mc_len_d   = mc_len;
        mc_data_d  = mc_data;
        if_ready_d = if_ready;
        if_data_d  = if_data;
        ls_ready_d = ls_ready;
        ls_res_d   = ls_res;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    mc_valid_d = 1'b1;
                    if (pick_ls) begin
                        mc_wr_d   = ls_wr;
                        mc_addr_d = ls_addr;
                        mc_len_d  = ls_len;
                        mc_data_d = ls_data;
                        state_d   = ST_BUSY_LS;
                    end else begin
                        mc_wr_d   = 1'b0;
                        mc_addr_d = if_addr;
                        mc_len_d  = LEN_WORD;
                        mc_data_d = '0;
                        state_d   = ST_BUSY_IF;
                    end
                end
            end
            ST_BUSY_IF: begin
                if (flush_in) drop_d = 1'b1;
                if (mc_ready) begin
                    mc_valid_d = 1'b0;
                    state_d    = ST_GAP;
                    // A flushed fetch still drains on the bus but is never returned
                    if (!drop_q && !flush_in) begin
                        if_ready_d = 1'b1;
                        if_data_d  = mc_res;
                    end
                end
            end
            ST_BUSY_LS: begin
                if (mc_ready) begin
                    mc_valid_d = 1'b0;
                    ls_ready_d = 1'b1;
                    ls_res_d   = ls_ext;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if_ready_d = 1'b0;
                ls_ready_d = 1'b0;
                drop_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            drop_q   <= 1'b0;
            mc_valid <= 1'b0;
            mc_wr    <= 1'b0;
            mc_addr  <= '0;
            mc_len   <= '0;
            mc_data  <= '0;
            if_ready <= 1'b0;
            if_data  <= '0;
            ls_ready <= 1'b0;
            ls_res   <= '0;
        end else if (rdy_in) begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            mc_valid <= mc_valid_d;
            mc_wr    <= mc_wr_d;
            mc_addr  <= mc_addr_d;
            mc_len   <= mc_len_d;
            mc_data  <= mc_data_d;
            if_ready <= if_ready_d;
            if_data  <= if_data_d;
            ls_ready <= ls_ready_d;
            ls_res   <= ls_res_d;
        end
    end

endmodule
